// File: rtl/prime_checker.sv
// Iterative trial-division primality tester.
// Each candidate divisor is checked with a restoring shift-subtract remainder.
module prime_checker #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] num,
  output logic             done,
  output logic             prime,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [2:0] {
    IDLE,
    BOUND,
    DIV,
    EVAL,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] n_q, n_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] shf_q, shf_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             prime_q, prime_d;
  logic             busy_q, busy_d;

  logic [2*WIDTH-1:0] sq;
  logic [WIDTH:0]     t;
  logic [WIDTH:0]     div_ext;
  logic               is_small;
  logic               sq_gt;
  logic               div_last;
  logic               rem_zero;

  // Square is formed at double width so it can never wrap.
  assign sq       = {{WIDTH{1'b0}}, div_q} * {{WIDTH{1'b0}}, div_q};
  assign sq_gt    = sq > {{WIDTH{1'b0}}, n_q};
  assign is_small = n_q < WIDTH'(2);
  assign div_last = cnt_q == CW'(WIDTH - 1);
  assign rem_zero = rem_q == '0;
  assign t        = {rem_q[WIDTH-1:0], shf_q[WIDTH-1]};
  assign div_ext  = {1'b0, div_q};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      n_q     <= '0;
      div_q   <= '0;
      rem_q   <= '0;
      shf_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      prime_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      div_q   <= div_d;
      rem_q   <= rem_d;
      shf_q   <= shf_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      prime_q <= prime_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: if (start) state_d = BOUND;
      BOUND: begin
        if (is_small || sq_gt) state_d = DONE;
        else                   state_d = DIV;
      end
      DIV:  if (div_last) state_d = EVAL;
      EVAL: state_d = rem_zero ? DONE : BOUND;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    n_d     = n_q;
    div_d   = div_q;
    rem_d   = rem_q;
    shf_d   = shf_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    prime_d = prime_q;
    busy_d  = busy_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          n_d    = num;
          div_d  = WIDTH'(2);
          busy_d = 1'b1;
          done_d = 1'b0;
        end
      end
      BOUND: begin
        if (is_small || sq_gt) begin
          prime_d = !is_small;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          rem_d = '0;
          shf_d = n_q;
          cnt_d = '0;
        end
      end
      DIV: begin
        shf_d = shf_q << 1;
        rem_d = (t >= div_ext) ? t - div_ext : t;
        cnt_d = cnt_q + CW'(1);
      end
      EVAL: begin
        if (rem_zero) begin
          prime_d = 1'b0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          div_d = div_q + WIDTH'(1);
        end
      end
      default: ;
    endcase
  end

  assign done  = done_q;
  assign prime = prime_q;
  assign busy  = busy_q;

endmodule
